// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN to add the signed (DIV) magnitude and negate path.
module seq_restoring_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             restore_sel
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem_acc, quo_acc, dsr_mag, dvd_orig;
    logic [CNT_W-1:0] cnt;
    logic             dbz;

    logic [WIDTH-1:0] shifted, rem_nxt, quo_nxt;
    logic [WIDTH-1:0] dvd_in_mag, dsr_in_mag, q_fix, r_fix;
    logic [WIDTH:0]   trial;
    logic             last;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q, neg_r, sgn_a, sgn_b;

    always_comb begin
        sgn_a      = is_signed & dividend[WIDTH-1];
        sgn_b      = is_signed & divisor[WIDTH-1];
        dvd_in_mag = sgn_a ? -dividend : dividend;
        dsr_in_mag = sgn_b ? -divisor : divisor;
        q_fix      = neg_q ? -quo_nxt : quo_nxt;
        r_fix      = neg_r ? -rem_nxt : rem_nxt;
    end
`else
    logic unused_sign;

    assign unused_sign = is_signed;

    always_comb begin
        dvd_in_mag = dividend;
        dsr_in_mag = divisor;
        q_fix      = quo_nxt;
        r_fix      = rem_nxt;
    end
`endif

    // Borrow out of the WIDTH+1 trial subtract decides keep vs. restore.
    always_comb begin
        shifted     = {rem_acc[WIDTH-2:0], quo_acc[WIDTH-1]};
        trial       = {1'b0, shifted} - {1'b0, dsr_mag};
        restore_sel = (state == RUN) & ~trial[WIDTH];
        rem_nxt     = restore_sel ? trial[WIDTH-1:0] : shifted;
        quo_nxt     = {quo_acc[WIDTH-2:0], restore_sel};
        last        = (cnt == CNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_acc   <= '0;
            quo_acc   <= '0;
            dsr_mag   <= '0;
            dvd_orig  <= '0;
            cnt       <= '0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            rem_acc  <= '0;
            quo_acc  <= dvd_in_mag;
            dsr_mag  <= dsr_in_mag;
            dvd_orig <= dividend;
            cnt      <= CNT_W'(WIDTH);
            dbz      <= (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
            neg_q    <= sgn_a ^ sgn_b;
            neg_r    <= sgn_a;
`endif
        end else if (state == RUN) begin
            rem_acc <= rem_nxt;
            quo_acc <= quo_nxt;
            cnt     <= cnt - CNT_W'(1);
            // Zero divisor reports all-ones and the untouched dividend.
            if (last) begin
                quotient  <= dbz ? '1 : q_fix;
                remainder <= dbz ? dvd_orig : r_fix;
            end
        end
    end

    assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider with a result scoreboard.
module tb_seq_restoring_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         restore_sel;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    seq_restoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .is_signed(is_signed),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .restore_sel(restore_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives start so it is sampled at the next edge; returns in cycle 1.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic push,
                            input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic ez);
        exp_t e;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        if (push) begin
            e.q = eq;
            e.r = er;
            e.z = {{(W-1){1'b0}}, ez};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input int sel_exp, input int inj);
        exp_t e;
        int   sel_cnt = 0;
        for (int c = 1; c <= W + 1; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == inj) begin
                start    = 1'b1;
                dividend = 9;
                divisor  = 3;
            end else begin
                start = 1'b0;
            end
            chk({tag, "_busydone"}, {30'd0, busy, done},
                {30'd0, (c <= W), (c == W + 1)});
            if (busy && restore_sel) sel_cnt++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_q"}, quotient, e.q);
            chk({tag, "_r"}, remainder, e.r);
            chk({tag, "_dbz"}, {31'd0, div_by_zero}, e.z);
        end
        if (sel_exp >= 0) chk({tag, "_selcnt"}, sel_cnt, sel_exp);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 0);
        if (e.q !== 'x) chk({tag, "_qhold"}, quotient, e.q);
    endtask

    initial begin
        logic [W-1:0] a, b;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("rst_ctl", {28'd0, busy, done, div_by_zero, restore_sel}, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        @(negedge clk);
        rst = 1'b0;

        do_start(100, 7, 0, 1, 14, 2, 0);
        run_op("u100_7", -1, 0);

        do_start(32'hFFFF_FFFF, 1, 0, 1, 32'hFFFF_FFFF, 0, 0);
        run_op("ffff_1", W, 0);

        do_start(5, 0, 0, 1, 32'hFFFF_FFFF, 5, 1);
        run_op("div0", -1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("div0_flag_hold", {31'd0, div_by_zero}, 1);

`ifdef DIVIDER_SIGNED_EN
        do_start(32'hFFFF_FFF9, 2, 1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        chk("dbz_clear", {31'd0, div_by_zero}, 0);
        run_op("s_m7_2", -1, 0);
        do_start(32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h8000_0000, 0, 0);
        run_op("s_ovf", -1, 0);
        do_start(5, 0, 1, 1, 32'hFFFF_FFFF, 5, 1);
        run_op("s_div0", -1, 0);
`else
        do_start(32'hFFFF_FFF9, 2, 1, 1, 32'h7FFF_FFFC, 1, 0);
        chk("dbz_clear", {31'd0, div_by_zero}, 0);
        run_op("sig_ignored", -1, 0);
`endif

        do_start(100, 7, 0, 1, 14, 2, 0);
        run_op("ignore_start", -1, 10);
        do_start(9, 3, 0, 1, 3, 0, 0);
        run_op("u9_3", -1, 0);

        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            do_start(a, b, 0, 1, a / b, a % b, 0);
            run_op("rand", -1, 0);
        end

        do_start(100, 7, 0, 0, 0, 0, 0);
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_ctl", {28'd0, busy, done, div_by_zero, restore_sel}, 0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            chk("midrst_nodone", {30'd0, busy, done}, 0);
        end
        do_start(50, 5, 0, 1, 10, 0, 0);
        run_op("u50_5", -1, 0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
